data_ram_ctrl: RTL and testbench

Parametrised data memory for the RV32 core's load/store path. Replaces the plain word RAM with byte, halfword and word access (RISC-V funct3 encoding), sign or zero extension, and misalignment detection. Uses a valid/ready request handshake with configurable wait states, and clears memory with a one-word-per-cycle sequencer instead of an array-wide reset. Sits between the core's MEM stage and the word-addressed storage array.

---
 rtl/data_ram_pkg.sv | 20 ++
 rtl/data_ram_lane_align.sv | 63 ++++++
 rtl/data_ram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_ram_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared encodings for the data RAM controller: RISC-V load/store size codes, FSM states, wait counter width.
// The top-level controller optionally runs a zeroing sequence after reset (DATA_RAM_INIT_CLEAR_EN).
package data_ram_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/data_ram_lane_align.sv
// Byte-lane steering: store byte enables/replicated data, load extension, misalignment/illegal-code flag.
// Purely combinational, no backpressure.
module data_ram_lane_align
  import data_ram_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    err_o   = 1'b0;
    rdata_o = '0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rbyte[7]}}, rbyte};
      end
      F3_BU: begin
        err_o   = we_i;
        rdata_o = {24'h0, rbyte};
      end
      F3_H: begin
        err_o   = addr_lo_i[0];
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{rhalf[15]}}, rhalf};
      end
      F3_HU: begin
        err_o   = we_i | addr_lo_i[0];
        rdata_o = {16'h0, rhalf};
      end
      F3_W: begin
        err_o   = |addr_lo_i;
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: err_o = 1'b1;
    endcase
    // A faulting access must neither write nor return data.
    if (err_o) begin
      be_o    = 4'b0000;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Byte/half/word data RAM with valid/ready request, 1+WAIT_CYCLES response latency, one request outstanding;
// req_ready is low outside IDLE. DATA_RAM_INIT_CLEAR_EN enables the post-reset one-word-per-cycle clear.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
`ifdef DATA_RAM_INIT_CLEAR_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [1:0]              lane_q;
  logic [31:0]             rword_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    accept;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [3:0]              wr_be;
  logic [31:0]             wr_dat;
  logic                    wr_err;
  logic [31:0]             rd_ext;
  logic                    rd_err;
  logic                    mem_we;
  logic [3:0]              mem_be;
  logic [DEPTH_LOG2-1:0]   mem_idx;
  logic [31:0]             mem_wdat;

  logic [31:0]             unused_wr_rdata;
  logic [3:0]              unused_rd_be;
  logic [31:0]             unused_rd_wdat;
  logic                    unused_addr_hi;

  assign accept         = req_valid && req_ready;
  assign req_idx        = req_addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

  data_ram_lane_align u_wr_align (
    .we_i      (req_we),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .rword_i   (32'h0),
    .be_o      (wr_be),
    .wdata_o   (wr_dat),
    .err_o     (wr_err),
    .rdata_o   (unused_wr_rdata)
  );

  data_ram_lane_align u_rd_align (
    .we_i      (we_q),
    .funct3_i  (funct3_q),
    .addr_lo_i (lane_q),
    .wdata_i   (32'h0),
    .rword_i   (rword_q),
    .be_o      (unused_rd_be),
    .wdata_o   (unused_rd_wdat),
    .err_o     (rd_err),
    .rdata_o   (rd_ext)
  );

`ifdef DATA_RAM_INIT_CLEAR_EN
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;

  assign ptr_d = (state_q == ST_INIT) ? ptr_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Single write port shared by the clear sequencer and committed stores.
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_idx  = req_idx;
    mem_wdat = wr_dat;
`ifdef DATA_RAM_INIT_CLEAR_EN
    if (state_q == ST_INIT) begin
      mem_we   = 1'b1;
      mem_be   = 4'hF;
      mem_idx  = ptr_q;
      mem_wdat = '0;
    end else
`endif
    if (accept && req_we && !wr_err) begin
      mem_we = 1'b1;
      mem_be = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
    if (accept) rword_q <= mem_q[req_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      lane_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        lane_q   <= req_addr[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
`ifdef DATA_RAM_INIT_CLEAR_EN
        if (&ptr_q) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = rsp_valid && rd_err;
    rsp_rdata = (rsp_valid && !we_q && !rd_err) ? rd_ext : 32'h0;
`ifdef DATA_RAM_INIT_CLEAR_EN
    init_busy = (state_q == ST_INIT);
`else
    init_busy = 1'b0;
`endif
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: directed scenarios plus randomized accesses against a byte-array reference model.
// Adapts its reset/clear expectations to DATA_RAM_INIT_CLEAR_EN.
module tb_data_ram_ctrl;

  localparam int unsigned DL2   = 10;
  localparam int unsigned WAITC = 3;
  localparam int unsigned BYTES = 4 << DL2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [BYTES];
  bit          ready_bad;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, size = 1<<funct3[1:0], natural alignment required.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int size;
    int a;
    logic [31:0] v;
    size = 1 << f3[1:0];
    a    = int'(addr % BYTES);
    err  = 1'b0;
    rd   = 32'h0;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) err = 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
    if ((a % size) != 0) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int b = 0; b < size; b++) ref_mem[a + b] = wd[8*b +: 8];
    end else begin
      v = 32'h0;
      for (int b = 0; b < size; b++) v[8*b +: 8] = ref_mem[a + b];
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
      rd = v;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat, output bit ok);
    int k;
    ok  = 1'b0;
    lat = 0;
    err = 1'b0;
    rd  = 32'h0;
    ready_bad = 1'b0;
    @(negedge clk);
    k = 0;
    while (req_ready !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      if (rsp_valid === 1'b1) begin
        lat = i + 1;
        ok  = 1'b1;
        err = rsp_err;
        rd  = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    bit          ok;
    model(we, f3, addr, wd, exp_err, exp_rd);
    do_req(we, f3, addr, wd, err, rd, lat, ok);
    check32({tag, ".rsp_seen"}, 32'(ok), 32'd1);
    check32({tag, ".latency"}, lat, 1 + WAITC);
    check32({tag, ".ready_low"}, 32'(ready_bad), 32'd0);
    check32({tag, ".err"}, 32'(err), 32'(exp_err));
    check32({tag, ".rdata"}, rd, exp_rd);
  endtask

  task automatic chk_ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] lit);
    logic        err;
    logic [31:0] rd;
    chk_req(tag, 1'b0, f3, addr, 32'h0, err, rd);
    check32({tag, ".literal"}, rd, lit);
  endtask

  task automatic measure_init(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (init_busy === 1'b1 && n < 5000);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    int          lat;
    int          n;
    bit          ok;
    bit          rsp_leak;
    logic [31:0] a;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst.rsp_err",   32'(rsp_err),   32'd0);
    check32("rst.rsp_rdata", rsp_rdata,      32'h0);
`ifdef DATA_RAM_INIT_CLEAR_EN
    check32("rst.init_busy", 32'(init_busy), 32'd1);
    check32("rst.req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    measure_init(n);
    check32("init.cycles", n, 1 << DL2);
    check32("init.ready",  32'(req_ready), 32'd1);
`else
    check32("rst.init_busy", 32'(init_busy), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check32("rel.ready", 32'(req_ready), 32'd1);
    check32("rel.init_busy", 32'(init_busy), 32'd0);
    // Contents are undefined without the clear; zero them through the request port.
    for (int i = 0; i < (1 << DL2); i++) do_req(1'b1, 3'b010, 32'(i * 4), 32'h0, e, r, lat, ok);
`endif

    // 1. Top word reads zero
    chk_ld("t1.lw_ffc", 3'b010, 32'h0000_0FFC, 32'h0);

    // 2. Round trip with extension
    chk_req("t2.sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, e, r);
    chk_ld("t2.lb",  3'b000, 32'h13, 32'hFFFF_FFDE);
    chk_ld("t2.lbu", 3'b100, 32'h13, 32'h0000_00DE);
    chk_ld("t2.lh",  3'b001, 32'h12, 32'hFFFF_DEAD);
    chk_ld("t2.lhu", 3'b101, 32'h10, 32'h0000_BEEF);

    // 3. Byte enables
    chk_req("t3.sw", 1'b1, 3'b010, 32'h20, 32'h1122_3344, e, r);
    chk_req("t3.sb", 1'b1, 3'b000, 32'h21, 32'h0000_00AA, e, r);
    chk_req("t3.sh", 1'b1, 3'b001, 32'h22, 32'h0000_5566, e, r);
    chk_ld("t3.lw", 3'b010, 32'h20, 32'h5566_AA44);

    // 4. Misalignment and illegal codes
    chk_req("t4.sw_mis", 1'b1, 3'b010, 32'h31, 32'h1234_5678, e, r);
    check32("t4.sw_mis.err_lit", 32'(e), 32'd1);
    chk_ld("t4.lw_30", 3'b010, 32'h30, 32'h0);
    chk_req("t4.lh_mis", 1'b0, 3'b001, 32'h33, 32'h0, e, r);
    check32("t4.lh_mis.err_lit", 32'(e), 32'd1);
    chk_req("t4.sbu_ill", 1'b1, 3'b100, 32'h30, 32'hFFFF_FFFF, e, r);
    chk_ld("t4.lw_30b", 3'b010, 32'h30, 32'h0);

    // 5. Address wrap
    chk_req("t5.sw_wrap", 1'b1, 3'b010, 32'h1004, 32'h0BAD_F00D, e, r);
    chk_ld("t5.lw_4", 3'b010, 32'h0004, 32'h0BAD_F00D);

    // Randomized traffic, clustered so loads hit earlier stores
    for (int i = 0; i < 150; i++) begin
      a = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(0, 63));
      else                          a = a | 32'($urandom_range(12'hFC0, 12'hFFF));
      chk_req("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, e, r);
    end

    // 6. Reset during WAIT of a store
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFE_F00D;
    model(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, e, r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    rsp_leak  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) rsp_leak = 1'b1;
    end
`ifdef DATA_RAM_INIT_CLEAR_EN
    check32("t6.rst_busy", 32'(init_busy), 32'd1);
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    reset_n = 1'b1;
    measure_init(n);
    check32("t6.init_cycles", n, 1 << DL2);
`else
    check32("t6.rst_busy", 32'(init_busy), 32'd0);
    reset_n = 1'b1;
    repeat (WAITC + 3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) rsp_leak = 1'b1;
    end
`endif
    check32("t6.no_rsp", 32'(rsp_leak), 32'd0);
`ifdef DATA_RAM_INIT_CLEAR_EN
    chk_ld("t6.lw_40", 3'b010, 32'h40, 32'h0);
`else
    chk_ld("t6.lw_40", 3'b010, 32'h40, 32'hCAFE_F00D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
